// File: rtl/load_store_unit.sv
// load_store_unit: byte/word load-store engine over a single-port word memory.
// Byte stores are done as read-modify-write; byte lanes are big-endian.
module load_store_unit #(
    parameter int WORD_SIZE = 32,
    parameter int MEM_AW    = 30
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic                 req_byte,
    input  logic [31:0]          req_addr,
    input  logic [WORD_SIZE-1:0] req_wdata,
    output logic                 resp_valid,
    output logic [WORD_SIZE-1:0] resp_data,
    output logic                 resp_err,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [MEM_AW-1:0]    mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    input  logic                 mem_ack,
    output logic [15:0]          load_cnt,
    output logic [15:0]          store_cnt
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t               r_state, w_next;
    logic                 r_we, r_byte, r_err;
    logic [31:0]          r_addr;
    logic [WORD_SIZE-1:0] r_wdata, r_data;
    logic [15:0]          r_load_cnt, r_store_cnt;
    logic                 w_accept, w_misaligned;
    logic [4:0]           w_shift;
    logic [7:0]           w_rbyte;
    logic [WORD_SIZE-1:0] w_lane_mask, w_merged, w_load_val;

    assign w_accept     = req_valid & req_ready;
    assign w_misaligned = ~req_byte & |req_addr[1:0];
    // offset 0 is the most significant byte
    assign w_shift      = {~r_addr[1:0], 3'b000};
    assign w_rbyte      = 8'(mem_rdata >> w_shift);
    assign w_lane_mask  = WORD_SIZE'(8'hFF) << w_shift;
    assign w_merged     = (mem_rdata & ~w_lane_mask) | (WORD_SIZE'(r_wdata[7:0]) << w_shift);
    assign w_load_val   = r_byte ? {{(WORD_SIZE-8){w_rbyte[7]}}, w_rbyte} : mem_rdata;

    assign mem_addr  = r_addr[MEM_AW+1:2];
    assign mem_wdata = r_wdata;
    assign resp_data = r_data;
    assign load_cnt  = r_load_cnt;
    assign store_cnt = r_store_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        req_ready  = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        unique case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    w_next = w_misaligned ? RESP : (req_we & ~req_byte) ? WRITE : READ;
            end
            READ: begin
                mem_req = 1'b1;
                if (mem_ack) w_next = r_we ? WRITE : RESP;
            end
            WRITE: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ack) w_next = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = r_err;
                w_next     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we        <= 1'b0;
            r_byte      <= 1'b0;
            r_err       <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_data      <= '0;
            r_load_cnt  <= '0;
            r_store_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_we    <= req_we;
                r_byte  <= req_byte;
                r_err   <= w_misaligned;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_data  <= '0;
            end
            // a byte store turns its read into the merged write word
            if (r_state == READ && mem_ack) begin
                if (r_we) r_wdata <= w_merged;
                else      r_data  <= w_load_val;
            end
            if (r_state == RESP && !r_err) begin
                if (r_we) r_store_cnt <= &r_store_cnt ? r_store_cnt : r_store_cnt + 16'd1;
                else      r_load_cnt  <= &r_load_cnt ? r_load_cnt : r_load_cnt + 16'd1;
            end
        end
    end
endmodule
